// File: rtl/scrambler_frame_ctrl.sv
// ---------------------------------------------------------------------------
// scrambler_frame_ctrl
//
// Frame-aware front end for an external additive scrambler. The first
// HDR_WORDS words of every frame pass through unscrambled. Later words are
// sent to the scrambler and its registered result is forwarded. A one-deep
// output register decouples the upstream and downstream handshakes.
//
// Optional feature (macro SCRAM_FRAME_STATS_EN): adds the frame_cnt and
// drop_cnt statistics outputs.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready   upstream handshake; s_data, s_sof, s_eof word + framing
//   scr_data_in       word presented to the scrambler (copy of s_data)
//   scr_en / scr_rst  scrambler advance / reseed strobes
//   scr_data_out      scrambler result, valid the cycle after scr_en
//   m_valid/m_ready   downstream handshake; m_data, m_sof, m_eof word + framing
//   err               sticky protocol error (stray word or unexpected sof)
//   frame_cnt         (stats build) frames completed, wraps at 16 bits
//   drop_cnt          (stats build) stray words dropped in IDLE, wraps
// ---------------------------------------------------------------------------
module scrambler_frame_ctrl #(
    parameter int HDR_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic [31:0] scr_data_in,
    output logic        scr_en,
    output logic        scr_rst,
    input  logic [31:0] scr_data_out,
    output logic        m_valid,
    output logic        m_sof,
    output logic        m_eof,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        err
`ifdef SCRAM_FRAME_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    localparam logic [3:0] HDR_LAST = 4'(HDR_WORDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic        m_valid_q, m_valid_d;
    logic        m_sof_q, m_sof_d;
    logic        m_eof_q, m_eof_d;
    logic [31:0] byp_q, byp_d;
    logic        pay_q, pay_d;     // output word came from the scrambler
    logic        err_q, err_d;

    logic accept;
    logic drop;

    assign s_ready     = !m_valid_q || m_ready;
    assign accept      = s_valid && s_ready;
    // A word without sof outside a frame has nowhere to go.
    assign drop        = accept && (state_q == IDLE) && !s_sof;
    assign scr_data_in = s_data;
    // An sof word is always a header word, even when it cuts into a payload.
    assign scr_en      = !rst && accept && (state_q == PAYLOAD) && !s_sof;
    // Reseed on every frame start so each payload begins from the seed.
    assign scr_rst     = rst || (accept && s_sof);

    assign m_valid = m_valid_q;
    assign m_sof   = m_sof_q;
    assign m_eof   = m_eof_q;
    // scr_data_out only moves on scr_en, which cannot fire during a stall,
    // so the payload word holds while m_valid && !m_ready.
    assign m_data  = pay_q ? scr_data_out : byp_q;
    assign err     = err_q;

    // Next-state / framing decode.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        err_d     = err_q;
        if (accept) begin
            if (s_sof) begin
                // sof inside a frame abandons that frame and starts afresh.
                if (state_q != IDLE) err_d = 1'b1;
                hdr_cnt_d = 4'd1;
                if (s_eof) begin
                    state_d   = IDLE;
                    hdr_cnt_d = 4'd0;
                end else if (HDR_WORDS == 1) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d = HDR;
                end
            end else begin
                case (state_q)
                    IDLE: err_d = 1'b1;
                    HDR: begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        if (s_eof) begin
                            state_d   = IDLE;
                            hdr_cnt_d = 4'd0;
                        end else if (hdr_cnt_q == HDR_LAST) begin
                            state_d = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (s_eof) begin
                            state_d   = IDLE;
                            hdr_cnt_d = 4'd0;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        hdr_cnt_d = 4'd0;
                    end
                endcase
            end
        end
    end

    // Output register next-state.
    always_comb begin
        m_valid_d = m_valid_q;
        m_sof_d   = m_sof_q;
        m_eof_d   = m_eof_q;
        byp_d     = byp_q;
        pay_d     = pay_q;
        if (accept && !drop) begin
            m_valid_d = 1'b1;
            m_sof_d   = s_sof;
            m_eof_d   = s_eof;
            byp_d     = s_data;
            pay_d     = scr_en;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_cnt_q <= 4'd0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            byp_q     <= 32'd0;
            pay_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            m_valid_q <= m_valid_d;
            m_sof_q   <= m_sof_d;
            m_eof_q   <= m_eof_d;
            byp_q     <= byp_d;
            pay_q     <= pay_d;
            err_q     <= err_d;
        end
    end

`ifdef SCRAM_FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A dropped stray word never completes a frame, even if it carries eof.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept && s_eof && !drop) frame_cnt_d = frame_cnt_q + 16'd1;
        if (drop)                     drop_cnt_d  = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scrambler_frame_ctrl
//
// Directed stimulus with hand-computed expectations, plus a frame-level
// reference model checked against the DUT on every falling edge. The bench
// also provides the external scrambler: 16-bit LFSR x^16+x^14+x^13+x^11,
// seed 0xDEAD, keystream word {lfsr, ~lfsr}, advanced once per scr_en.
// ---------------------------------------------------------------------------
module tb_scrambler_frame_ctrl;

    localparam int HDR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        s_sof = 1'b0;
    logic        s_eof = 1'b0;
    logic [31:0] scr_data_in;
    logic        scr_en;
    logic        scr_rst;
    logic [31:0] scr_data_out;
    logic        m_valid, m_sof, m_eof;
    logic [31:0] m_data;
    logic        m_ready = 1'b1;
    logic        err;
`ifdef SCRAM_FRAME_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    scrambler_frame_ctrl #(.HDR_WORDS(HDR)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof),
        .scr_data_in(scr_data_in), .scr_en(scr_en), .scr_rst(scr_rst),
        .scr_data_out(scr_data_out),
        .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof), .m_data(m_data),
        .m_ready(m_ready), .err(err)
`ifdef SCRAM_FRAME_STATS_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- external scrambler ----------------
    logic [15:0] lfsr_s = 16'hDEAD;
    logic [31:0] scr_out_s = 32'd0;
    assign scr_data_out = scr_out_s;

    always @(posedge clk) begin
        if (scr_rst) lfsr_s <= 16'hDEAD;
        else if (scr_en) begin
            scr_out_s <= scr_data_in ^ {lfsr_s, ~lfsr_s};
            lfsr_s    <= {lfsr_s[14:0], lfsr_s[15] ^ lfsr_s[13] ^ lfsr_s[12] ^ lfsr_s[10]};
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Keystream word n positions after a reseed.
    function automatic logic [31:0] ks_at(input int n);
        logic [15:0] l;
        l = 16'hDEAD;
        for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return {l, ~l};
    endfunction

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t q[$];
    bit   in_frame = 0;
    int   pos      = 0;   // words already accepted in the current frame
    int   pidx     = 0;   // payload words already scrambled in this frame
    bit   exp_err  = 0;
    int   frames   = 0;
    int   drops    = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_scr_rst", 32'(scr_rst), 32'd1);
            check("rst_scr_en", 32'(scr_en), 32'd0);
            q.delete();
            in_frame = 0; pos = 0; pidx = 0; exp_err = 0; frames = 0; drops = 0;
        end else begin
            bit   rdy, acc, pay;
            exp_t e;
            rdy = (q.size() == 0) || m_ready;
            acc = s_valid && rdy;
            pay = acc && in_frame && !s_sof && (pos >= HDR);
            check("s_ready", 32'(s_ready), 32'(rdy));
            check("scr_en", 32'(scr_en), 32'(pay));
            check("scr_rst", 32'(scr_rst), 32'(acc && s_sof));
            check("m_valid", 32'(m_valid), 32'(q.size() != 0));
            check("err", 32'(err), 32'(exp_err));
            if (q.size() != 0 && m_valid) begin
                check("m_data", m_data, q[0].d);
                check("m_sof", 32'(m_sof), 32'(q[0].sof));
                check("m_eof", 32'(m_eof), 32'(q[0].eof));
            end
`ifdef SCRAM_FRAME_STATS_EN
            check("frame_cnt", 32'(frame_cnt), 32'(frames[15:0]));
            check("drop_cnt", 32'(drop_cnt), 32'(drops[15:0]));
`endif
            // Predict the effect of the coming rising edge.
            if (q.size() != 0 && m_ready) void'(q.pop_front());
            if (acc) begin
                if (s_sof) begin
                    if (in_frame) exp_err = 1;
                    in_frame = !s_eof;
                    pos = 1; pidx = 0;
                    e.d = s_data; e.sof = 1'b1; e.eof = s_eof;
                    q.push_back(e);
                    if (s_eof) frames++;
                end else if (!in_frame) begin
                    exp_err = 1;
                    drops++;
                end else begin
                    e.d = pay ? (s_data ^ ks_at(pidx)) : s_data;
                    if (pay) pidx++;
                    e.sof = 1'b0; e.eof = s_eof;
                    pos++;
                    q.push_back(e);
                    if (s_eof) begin in_frame = 0; frames++; end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_rdy = 0;

    // Present one word and hold it until accepted; returns just after the
    // accepting edge, so the word is then in the output register.
    task automatic send(input logic [31:0] d, input logic sof, input logic eof);
        bit ok;
        ok = 0;
        s_data = d; s_sof = sof; s_eof = eof; s_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (s_valid && s_ready) ok = 1;
            @(posedge clk); #1;
            if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            send(base + 32'(i * 32'h01010101), i == 0, i == n - 1);
    endtask

    initial begin
        #1;
        check("reset_m_data", m_data, 32'd0);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Two identical 5-word frames, downstream always ready.
        for (int f = 0; f < 2; f++) begin
            send(32'h11110000, 1, 0);
            check("hdr0_bypass", m_data, 32'h11110000);
            send(32'h22220000, 0, 0);
            check("hdr1_bypass", m_data, 32'h22220000);
            send(32'h00000000, 0, 0);
            check("pay0_seed", m_data, 32'hDEAD2152);
            send(32'h00000000, 0, 0);
            check("pay1_step", m_data, 32'hBD5B42A4);
            send(32'h55555555, 0, 1);
            check("pay2_eof", 32'(m_eof), 32'd1);
        end

        // Downstream stall across three cycles mid-payload.
        send(32'h11110000, 1, 0);
        send(32'h22220000, 0, 0);
        send(32'h00000000, 0, 0);
        m_ready = 1'b0;
        s_data = 32'h00000000; s_sof = 1'b0; s_eof = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_scr_en", 32'(scr_en), 32'd0);
            check("stall_m_data", m_data, 32'hDEAD2152);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(32'h00000000, 0, 0);
        check("after_stall", m_data, 32'hBD5B42A4);
        send(32'h55555555, 0, 1);

        // Stray word outside a frame.
        send(32'h12345678, 0, 0);
        check("drop_m_valid", 32'(m_valid), 32'd0);
        check("drop_err", 32'(err), 32'd1);
`ifdef SCRAM_FRAME_STATS_EN
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif

        // sof cutting into a payload restarts header and seed.
        send(32'hAAAA0000, 1, 0);
        send(32'hAAAA0001, 0, 0);
        send(32'h00000000, 0, 0);
        send(32'h0F0F0F0F, 0, 0);
        send(32'hBBBB0000, 1, 0);
        check("resof_hdr", m_data, 32'hBBBB0000);
        check("resof_m_sof", 32'(m_sof), 32'd1);
        send(32'hCCCC0000, 0, 0);
        send(32'h00000000, 0, 0);
        check("resof_seed", m_data, 32'hDEAD2152);
        check("resof_err", 32'(err), 32'd1);

        // Reset in the middle of the payload.
        rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
`ifdef SCRAM_FRAME_STATS_EN
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        check("postrst_m_valid", 32'(m_valid), 32'd0);

        // Frame continuation after reset is a stray word.
        send(32'h00000001, 0, 0);
        check("postrst_drop_err", 32'(err), 32'd1);

        // Mixed frame shapes with a random downstream.
        rand_rdy = 1;
        send_frame(32'h10000000, 5);
        send_frame(32'h20000000, 2);
        send_frame(32'h30000000, 1);
        send_frame(32'h40000000, 6);
        send_frame(32'h50000000, 3);
        rand_rdy = 0;
        m_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_m_valid", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
